// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter producing one-hot-or-zero enables for N tristate drivers
// sharing a single bus wire. Every ownership change passes through a turnaround
// gap with all enables low, so no two drivers ever overlap on the wire.
module tristate_bus_arbiter #(
  parameter int N_MASTERS  = 4,
  parameter int HOLD_MAX   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_MASTERS-1:0]         req,
  output logic [N_MASTERS-1:0]         sel,
  output logic [$clog2(N_MASTERS)-1:0] grant_id,
  output logic                         bus_busy
);

  localparam int IDW = $clog2(N_MASTERS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  logic [1:0]           state_reg;
  logic [IDW-1:0]       rr_ptr_reg;
  logic [7:0]           hold_cnt_reg;
  logic [3:0]           turn_cnt_reg;
  logic [N_MASTERS-1:0] sel_reg;
  logic [IDW-1:0]       grant_id_reg;
  logic                 bus_busy_reg;

  logic [IDW-1:0]       cand_idx [N_MASTERS];
  logic [N_MASTERS-1:0] cand_req;
  logic                 pick_valid;
  logic [IDW-1:0]       pick_idx;
  logic                 release_now;
  logic [IDW-1:0]       next_ptr;
  logic [N_MASTERS-1:0] one_bit;

  assign one_bit = {{(N_MASTERS-1){1'b0}}, 1'b1};

  // Candidate at scan offset gi is master (rr_ptr + gi) mod N_MASTERS; the
  // modulo is a single conditional subtract because both terms are < N.
  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDW+1)'(N_MASTERS))
                            ? IDW'(sum - (IDW+1)'(N_MASTERS))
                            : sum[IDW-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Pick the requesting candidate with the smallest offset from rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  // Owner lets go when it drops its request or exhausts its hold budget;
  // the pointer moves just past it so it becomes lowest priority next round.
  assign release_now = !req[grant_id_reg] || (hold_cnt_reg == 8'(HOLD_MAX));
  assign next_ptr    = (grant_id_reg == IDW'(N_MASTERS - 1)) ? '0 : grant_id_reg + 1'b1;

  // Arbitration FSM; all outputs come straight from these registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      hold_cnt_reg <= '0;
      turn_cnt_reg <= '0;
      sel_reg      <= '0;
      grant_id_reg <= '0;
      bus_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            sel_reg      <= one_bit << pick_idx;
            grant_id_reg <= pick_idx;
            bus_busy_reg <= 1'b1;
            hold_cnt_reg <= 8'd1;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            sel_reg      <= '0;
            rr_ptr_reg   <= next_ptr;
            turn_cnt_reg <= 4'(TURNAROUND);
            state_reg    <= TURN;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        TURN: begin
          turn_cnt_reg <= turn_cnt_reg - 4'd1;
          if (turn_cnt_reg == 4'd1) begin
            bus_busy_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          sel_reg      <= '0;
          bus_busy_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign sel      = sel_reg;
  assign grant_id = grant_id_reg;
  assign bus_busy = bus_busy_reg;

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter that generates the per-driver `sel` enables for N tristate buffers sharing one bus wire.
- Sits directly upstream of the tristate buffer stage; each `sel[i]` drives the `sel` input of buffer i.
- Guarantees at most one driver is enabled at any time.
- Inserts a programmable turnaround gap, with all `sel` low, between owners so drivers never overlap.

Parameters:
- N_MASTERS, 4: number of requesters / tristate drivers; legal range 2..16.
- HOLD_MAX, 8: maximum consecutive cycles one owner keeps `sel`; legal range 1..255.
- TURNAROUND, 1: cycles with all `sel` low after a release, before IDLE; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  N_MASTERS  request per master; level, held while bus wanted.
- sel  output  N_MASTERS  one-hot-or-zero driver enable, to tristate `sel` inputs; registered.
- grant_id  output  clog2(N_MASTERS)  index of current owner; valid while `sel` != 0; registered.
- bus_busy  output  1  high in GRANT and TURN states; registered.

Behaviour:
- Reset:
  - Asserting reset_n=0 takes effect immediately, without waiting for clk.
  - Reset values: sel=0, grant_id=0, bus_busy=0, state=IDLE, rr_ptr=0, hold_cnt=0, turn_cnt=0.
  - Reset mid-grant drops `sel` immediately, with no turnaround.
- States: IDLE, GRANT, TURN. All outputs are registered; there is no combinational path from `req` to `sel`.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the edge, choose the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_MASTERS.
  - Set sel=1<<i, grant_id=i, bus_busy=1, hold_cnt=1, and go to GRANT.
  - Latency: `sel` rises on the first edge after `req` is sampled high.
- GRANT:
  - Release condition: req[grant_id]==0, OR hold_cnt==HOLD_MAX.
  - Not released: hold_cnt increments each cycle.
  - Released, at that edge: sel=0, rr_ptr=(grant_id+1) mod N_MASTERS, turn_cnt=TURNAROUND, go to TURN.
  - grant_id keeps its last value.
  - Changes on other req bits are ignored during GRANT.
  - An owner whose req is still high after a HOLD_MAX release re-competes normally after TURN and gets the lowest priority.
- TURN:
  - sel=0 and bus_busy=1.
  - turn_cnt decrements each cycle; on the edge where turn_cnt==1, go to IDLE with bus_busy=0.
- Gap timing: `sel` is low for exactly TURNAROUND+1 cycles between consecutive owners, even when requests are continuous.
- Invariants, checked every cycle outside reset:
  - popcount(sel) <= 1.
  - sel != 0 implies state==GRANT and sel==1<<grant_id.
  - hold_cnt <= HOLD_MAX.
- Wrap-around:
  - rr_ptr wraps from N_MASTERS-1 to 0.
  - The scan wraps past index N_MASTERS-1 back to 0.
- Edge cases:
  - Owner drops req in the same cycle it is granted: release is evaluated on the next edge, so `sel` is high for 1 cycle minimum.
  - HOLD_MAX=1 gives every grant exactly 1 cycle.
  - req bits for nonexistent masters cannot occur, since width equals N_MASTERS.
- Counter widths:
  - hold_cnt is 8 bits.
  - turn_cnt is 4 bits.
  - No counter overflows within the legal parameter ranges.

Test Plan (N_MASTERS=4, HOLD_MAX=8, TURNAROUND=1, unless stated otherwise):
1. Reset, then req=4'b0000 for 5 cycles -> sel=0, grant_id=0, bus_busy=0 throughout.
2. req=4'b0100 held 3 cycles, then 0 -> sel=4'b0100 from edge 1 for 3 cycles, grant_id=2, then sel=0 with bus_busy=1 for 1 cycle, then bus_busy=0.
3. req=4'b1111 held continuously for 60 cycles:
   - Owner order is 0,1,2,3,0,...
   - Each owner holds sel for exactly 8 cycles.
   - Each gap is exactly 2 cycles of sel=0.
   - popcount(sel) <= 1 every cycle.
4. req=4'b1001 with rr_ptr=3 (after granting 2) -> master 3 is granted first, then master 0 (wrap-around scan).
5. Grant to master 1 (req=4'b0010), assert reset_n=0 mid-cycle, 3 cycles into the grant -> sel goes to 0 immediately without a clock edge. After release, the first grant goes to master 1 again (rr_ptr=0, so the scan reaches 1 first).
6. HOLD_MAX=1, TURNAROUND=3, req=4'b0011 continuous -> grants alternate 0,1,0,...; each lasts 1 cycle with 4-cycle sel=0 gaps.
